ime_search_feeder: RTL and testbench

- Producer side of the IME processing-element array.
- For one current macroblock, scans every candidate displacement in a square search window.
- For each candidate, streams N row-pairs (current-block row, reference row) to the PE array and asserts `roll` on the last row of each candidate.
- Fetches pixels from the current-block buffer and the reference-frame memory; tolerates downstream back-pressure.

---
 rtl/ime_search_feeder.sv | 184 ++++++++++++++++++
 tb/tb_ime_search_feeder.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/ime_search_feeder.sv
`default_nettype none
// ============================================================================
// ime_search_feeder : streams (current row, reference row) pairs per search
// candidate to the IME PE array. Optional abort port: IME_EARLY_ABORT_EN.
// Revision: 1.0
// ============================================================================
module ime_search_feeder #(
    parameter int N      = 16,
    parameter int RANGE  = 8,
    parameter int STRIDE = 64,
    parameter int AW     = 16
) (
    input  logic                                clk,
    input  logic                                rst,
`ifdef IME_EARLY_ABORT_EN
    input  logic                                abort,
    output logic                                aborted,
`endif
    input  logic                                start,
    input  logic [AW-1:0]                       base_x,
    input  logic [AW-1:0]                       base_y,
    output logic                                busy,
    output logic                                done,
    output logic                                cur_rd,
    output logic [$clog2(N)-1:0]                cur_addr,
    input  logic [N*8-1:0]                      cur_data,
    output logic                                ref_rd,
    output logic [AW-1:0]                       ref_addr,
    input  logic [N*8-1:0]                      ref_data,
    output logic [N*8-1:0]                      pe_a,
    output logic [N*8-1:0]                      pe_b,
    output logic                                out_valid,
    input  logic                                out_ready,
    output logic                                roll,
    output logic [$clog2(2*RANGE+1):0]          cand_dx,
    output logic [$clog2(2*RANGE+1):0]          cand_dy
);
    localparam int RW = $clog2(N);
    localparam int DW = $clog2(2*RANGE+1) + 1;
    localparam int PW = N*8;
    localparam int MW = 1 + 2*DW;
    localparam int EW = 2*PW + MW;
    localparam logic [DW-1:0] C_RMAX     = DW'(RANGE);
    localparam logic [DW-1:0] C_RMIN     = DW'(-RANGE);
    localparam logic [RW-1:0] C_LAST_ROW = RW'(N-1);

    typedef enum logic [1:0] {S_IDLE, S_SCAN, S_DRAIN, S_DONE} state_t;

    state_t          r_state;
    logic [AW-1:0]   r_base_x, r_base_y;
    logic [RW-1:0]   r_row;
    logic [DW-1:0]   r_dx, r_dy;
    logic            r_pend;
    logic [MW-1:0]   r_pend_meta;
    logic [EW-1:0]   r_fifo [2];
    logic            r_wptr, r_rptr;
    logic [1:0]      r_occ;

    logic            w_abort;
    logic            w_pop;
    logic [2:0]      w_outstanding;
    logic            w_issue;
    logic            w_last;
    logic [AW-1:0]   w_ref_y;
    logic [AW-1:0]   w_addr;

`ifdef IME_EARLY_ABORT_EN
    logic            r_aborted;
    assign w_abort = abort;
    assign aborted = done & r_aborted;
`else
    assign w_abort = 1'b0;
`endif

    assign out_valid = (r_occ != 2'd0);
    assign w_pop     = out_valid & out_ready;
    // Beats that will sit in the FIFO or still be in flight after this edge;
    // counting the pop this cycle is what allows one beat per cycle.
    assign w_outstanding = 3'(r_occ) + 3'(r_pend) - 3'(w_pop);
    assign w_issue   = (r_state == S_SCAN) && !w_abort && (w_outstanding < 3'd2);
    assign w_last    = (r_row == C_LAST_ROW) && (r_dx == C_RMAX) && (r_dy == C_RMAX);

    assign w_ref_y = r_base_y + {{(AW-DW){r_dy[DW-1]}}, r_dy} + AW'(r_row);
    assign w_addr  = w_ref_y * AW'(STRIDE) + r_base_x + {{(AW-DW){r_dx[DW-1]}}, r_dx};

    assign cur_rd   = w_issue;
    assign ref_rd   = w_issue;
    assign cur_addr = w_issue ? r_row  : '0;
    assign ref_addr = w_issue ? w_addr : '0;

    assign {pe_a, pe_b, roll, cand_dx, cand_dy} = r_fifo[r_rptr];
    assign busy = (r_state == S_SCAN) || (r_state == S_DRAIN);
    assign done = (r_state == S_DONE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= S_IDLE;
            r_base_x <= '0;
            r_base_y <= '0;
            r_row    <= '0;
            r_dx     <= '0;
            r_dy     <= '0;
`ifdef IME_EARLY_ABORT_EN
            r_aborted <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_base_x <= base_x;
                        r_base_y <= base_y;
                        r_row    <= '0;
                        r_dx     <= C_RMIN;
                        r_dy     <= C_RMIN;
                        r_state  <= S_SCAN;
`ifdef IME_EARLY_ABORT_EN
                        r_aborted <= 1'b0;
`endif
                    end
                end
                S_SCAN: begin
                    if (w_abort) begin
                        r_state <= S_DRAIN;
`ifdef IME_EARLY_ABORT_EN
                        r_aborted <= 1'b1;
`endif
                    end else if (w_issue) begin
                        if (w_last) begin
                            r_state <= S_DRAIN;
                        end
                        if (r_row == C_LAST_ROW) begin
                            r_row <= '0;
                            if (r_dx == C_RMAX) begin
                                r_dx <= C_RMIN;
                                r_dy <= r_dy + 1'b1;
                            end else begin
                                r_dx <= r_dx + 1'b1;
                            end
                        end else begin
                            r_row <= r_row + 1'b1;
                        end
                    end
                end
                S_DRAIN: begin
`ifdef IME_EARLY_ABORT_EN
                    if (w_abort) begin
                        r_aborted <= 1'b1;
                    end
`endif
                    if (w_outstanding == 3'd0) begin
                        r_state <= S_DONE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Read metadata rides alongside the memory latency and joins the data on write.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pend      <= 1'b0;
            r_pend_meta <= '0;
            r_fifo[0]   <= '0;
            r_fifo[1]   <= '0;
            r_wptr      <= 1'b0;
            r_rptr      <= 1'b0;
            r_occ       <= 2'd0;
        end else begin
            r_pend      <= w_issue;
            r_pend_meta <= {(r_row == C_LAST_ROW), r_dx, r_dy};
            if (r_pend) begin
                r_fifo[r_wptr] <= {cur_data, ref_data, r_pend_meta};
                r_wptr         <= ~r_wptr;
            end
            if (w_pop) begin
                r_rptr <= ~r_rptr;
            end
            r_occ <= r_occ + 2'(r_pend) - 2'(w_pop);
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ime_search_feeder.sv
`default_nettype none
// Self-checking bench for ime_search_feeder: randomized data and back-pressure,
// expected beats produced by a raster-order reference model into a scoreboard.
module tb_ime_search_feeder;
    localparam int N      = 4;
    localparam int RANGE  = 1;
    localparam int STRIDE = 16;
    localparam int AW     = 16;
    localparam int DW     = 3;
    localparam int PW     = N*8;
    localparam int NB     = (2*RANGE+1)*(2*RANGE+1)*N;

    typedef struct packed {
        logic [PW-1:0] a;
        logic [PW-1:0] b;
        logic          roll;
        logic [DW-1:0] dx;
        logic [DW-1:0] dy;
    } beat_t;

    logic clk, rst, start, busy, done, cur_rd, ref_rd, out_valid, out_ready, roll;
    logic [AW-1:0] base_x, base_y, ref_addr;
    logic [1:0]    cur_addr;
    logic [PW-1:0] cur_data, ref_data, pe_a, pe_b;
    logic [DW-1:0] cand_dx, cand_dy;
`ifdef IME_EARLY_ABORT_EN
    logic abort, aborted;
`endif

    ime_search_feeder #(.N(N), .RANGE(RANGE), .STRIDE(STRIDE), .AW(AW)) dut (
        .clk(clk), .rst(rst),
`ifdef IME_EARLY_ABORT_EN
        .abort(abort), .aborted(aborted),
`endif
        .start(start), .base_x(base_x), .base_y(base_y), .busy(busy), .done(done),
        .cur_rd(cur_rd), .cur_addr(cur_addr), .cur_data(cur_data),
        .ref_rd(ref_rd), .ref_addr(ref_addr), .ref_data(ref_data),
        .pe_a(pe_a), .pe_b(pe_b), .out_valid(out_valid), .out_ready(out_ready),
        .roll(roll), .cand_dx(cand_dx), .cand_dy(cand_dy)
    );

    int checks = 0;
    int errors = 0;
    int acc, rds, first_addr, mode;
    beat_t         exp_q[$];
    logic [AW-1:0] addr_q[$];
    logic [1:0]    row_q[$];
    logic [PW-1:0] cur_mem [N];
    bit            stalled_prev;
    beat_t         prev_beat;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [PW-1:0] ref_word(input logic [AW-1:0] a);
        return {a, ~a};
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Memories answer one cycle after the strobe; garbage otherwise.
    always @(posedge clk) begin
        cur_data <= cur_rd ? cur_mem[cur_addr] : PW'($urandom);
        ref_data <= ref_rd ? ref_word(ref_addr) : PW'($urandom);
    end

    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (mode)
                0:       out_ready = 1'b1;
                1:       out_ready = ~out_ready;
                2:       out_ready = 1'($urandom_range(0, 1));
                default: out_ready = 1'b0;
            endcase
        end
    end

    function automatic beat_t dut_beat();
        return '{a: pe_a, b: pe_b, roll: roll, dx: cand_dx, dy: cand_dy};
    endfunction

    // Monitor: read-address order, stall stability, and beat scoreboard.
    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                if (ref_rd) begin
                    rds++;
                    if (first_addr < 0) first_addr = int'(ref_addr);
                    if (addr_q.size() == 0) begin
                        check("extra_read", 1'b1, 1'b0);
                    end else begin
                        check("rd_pair", {cur_rd, cur_addr, ref_addr},
                              {1'b1, row_q.pop_front(), addr_q.pop_front()});
                    end
                end
                if (stalled_prev) begin
                    check("stall_stable", {out_valid, dut_beat()}, {1'b1, prev_beat});
                end
                if (out_valid && out_ready) begin
                    acc++;
                    if (exp_q.size() == 0) check("extra_beat", 1'b1, 1'b0);
                    else check("beat", 128'(dut_beat()), 128'(exp_q.pop_front()));
                end
                stalled_prev = out_valid && !out_ready;
                prev_beat    = dut_beat();
            end else begin
                stalled_prev = 1'b0;
            end
        end
    end

    task automatic model_scan(input int bx, input int by);
        for (int dy = -RANGE; dy <= RANGE; dy++)
            for (int dx = -RANGE; dx <= RANGE; dx++)
                for (int r = 0; r < N; r++) begin
                    logic [AW-1:0] a;
                    a = AW'((by + dy + r) * STRIDE + bx + dx);
                    exp_q.push_back('{a: cur_mem[r], b: ref_word(a), roll: (r == N-1),
                                      dx: DW'(dx), dy: DW'(dy)});
                    addr_q.push_back(a);
                    row_q.push_back(2'(r));
                end
    endtask

    task automatic run(input int bx, input int by, input int md, input int hold,
                       input bit repulse, input int rst_at, input int abort_at,
                       input int exp_beats);
        int first, done_c;
        exp_q.delete(); addr_q.delete(); row_q.delete();
        acc = 0; rds = 0; first_addr = -1;
        for (int r = 0; r < N; r++) cur_mem[r] = PW'($urandom);
        model_scan(bx, by);
        mode = (hold > 0) ? 3 : md;
        @(posedge clk); #1;
        base_x = AW'(bx); base_y = AW'(by); start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        first = -1; done_c = -1;
        for (int c = 0; c < 2000; c++) begin
            @(negedge clk);
            if (c == 0) check("busy_after_start", busy, 1'b1);
            if (out_valid && first < 0) first = c;
            if (hold > 0 && c == hold) begin
                check("stall_reads", rds, 2);
                check("stall_valid", out_valid, 1'b1);
                mode = md;
            end
            if (repulse && c == 10) begin start = 1'b1; base_x = AW'(bx + 7); end
            if (repulse && c == 11) start = 1'b0;
`ifdef IME_EARLY_ABORT_EN
            if (c == abort_at - 1) begin @(posedge clk); #1 abort = 1'b1; end
            if (c == abort_at)     begin @(posedge clk); #1 abort = 1'b0; end
`endif
            if (rst_at > 0 && acc >= rst_at) begin
                #2 rst = 1'b0;
                #1 check("reset_mid_outputs",
                         {busy, done, cur_rd, cur_addr, ref_rd, ref_addr, pe_a, pe_b,
                          out_valid, roll, cand_dx, cand_dy}, '0);
                exp_q.delete(); addr_q.delete(); row_q.delete();
                stalled_prev = 1'b0;
                @(posedge clk); #1 rst = 1'b1;
                return;
            end
            if (done) begin
                done_c = c;
`ifdef IME_EARLY_ABORT_EN
                check("aborted_flag", aborted, abort_at >= 0);
`endif
                break;
            end
        end
        check("done_seen", done_c >= 0, 1'b1);
        check("first_valid_latency", first, 2);
        check("beat_count", acc, exp_beats);
        if (md == 0 && hold == 0) check("done_cycle", done_c, 2 + exp_beats);
        if (bx == 4 && by == 4) check("first_ref_addr", first_addr, 51);
        @(negedge clk);
        check("done_pulse_end", {done, busy}, 2'b00);
    endtask

    initial begin
        rst = 1'b0; start = 1'b0; base_x = '0; base_y = '0; mode = 0;
        stalled_prev = 1'b0;
`ifdef IME_EARLY_ABORT_EN
        abort = 1'b0;
`endif
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_outputs",
              {busy, done, cur_rd, cur_addr, ref_rd, ref_addr, pe_a, pe_b,
               out_valid, roll, cand_dx, cand_dy}, '0);
        @(posedge clk); #1 rst = 1'b1;

        run(4, 4, 0, 0,  1'b0, -1, -1, NB);
        run(4, 4, 1, 0,  1'b0, -1, -1, NB);
        run(4, 4, 0, 10, 1'b0, -1, -1, NB);
        run(4, 4, 0, 0,  1'b1, -1, -1, NB);
        run(4, 4, 0, 0,  1'b0, 20, -1, NB);
        run(4, 4, 0, 0,  1'b0, -1, -1, NB);
        for (int k = 0; k < 3; k++)
            run(int'($urandom_range(8, 500)), int'($urandom_range(8, 500)), 2, 0, 1'b0, -1, -1, NB);
`ifdef IME_EARLY_ABORT_EN
        run(4, 4, 0, 0, 1'b0, -1, 10, 10);
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not end");
        $fatal(1);
    end
endmodule
`default_nettype wire
